// File: rtl/snowv_add_scheduler.sv
// Two-requester round-robin scheduler that time-shares a single 32-bit modulo-2^32
// adder across the LANES lanes of each SNOW-V lane-wise addition request.
module snowv_add_scheduler #(
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [32*LANES-1:0]   req0_a,
    input  logic [32*LANES-1:0]   req0_b,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [32*LANES-1:0]   req1_a,
    input  logic [32*LANES-1:0]   req1_b,
    output logic                  req1_ready,
    output logic                  res_valid,
    output logic [32*LANES-1:0]   res_data,
    output logic                  res_id,
    input  logic                  res_ready,
    output logic                  busy
);

    localparam int W  = 32 * LANES;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   lane;
    logic            gnt_id;
    logic            rr_ptr;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W-1:0]    result;
    logic [W-1:0]    result_nxt;
    logic [W-1:0]    res_q;

    logic            grant;
    logic            accept0;
    logic            accept1;
    logic            accept;
    logic            last_lane;
    logic [31:0]     add_a;
    logic [31:0]     add_b;
    logic [31:0]     add_sum;

    // Round-robin pointer only breaks ties; a lone requester is always granted.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it
        // unassigned and no latch is inferred; always_comb uses blocking '='.
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = rr_ptr;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept0   = (state == IDLE) && !rst && req0_valid && !grant;
    assign accept1   = (state == IDLE) && !rst && req1_valid &&  grant;
    assign accept    = accept0 || accept1;
    assign last_lane = (lane == LW'(LANES - 1));

    assign req0_ready = accept0;
    assign req1_ready = accept1;
    assign res_valid  = (state == DONE);
    assign res_data   = res_q;
    assign res_id     = gnt_id;
    assign busy       = (state != IDLE);

    // The one shared adder: carry out of bit 31 drops, nothing crosses lanes.
    assign add_a   = op_a[32*lane +: 32];
    assign add_b   = op_b[32*lane +: 32];
    assign add_sum = add_a + add_b;

    always_comb begin
        result_nxt                 = result;
        result_nxt[32*lane +: 32]  = add_sum;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = ADD;
            ADD:     if (last_lane) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state  <= IDLE;
            lane   <= '0;
            gnt_id <= 1'b0;
            rr_ptr <= 1'b0;
            res_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt_id <= grant;
                        lane   <= '0;
                    end
                end
                ADD: begin
                    lane <= lane + LW'(1);
                    if (last_lane) begin
                        res_q <= result_nxt;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        rr_ptr <= ~gnt_id;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: operand and working-result registers carry no reset; they are only
    // observed after being written, and leaving them unreset keeps them plain flops.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= grant ? req1_a : req0_a;
            op_b <= grant ? req1_b : req0_b;
        end
        if (state == ADD) begin
            result <= result_nxt;
        end
    end

    a_one_ready : assert property (@(posedge clk) disable iff (rst)
        !(req0_ready && req1_ready));

    a_no_ready_busy : assert property (@(posedge clk) disable iff (rst)
        busy |-> (!req0_ready && !req1_ready));

    a_res_hold : assert property (@(posedge clk) disable iff (rst)
        (res_valid && !res_ready) |=> (res_valid && $stable(res_data) && $stable(res_id)));

endmodule
